hex_word_entry: RTL and testbench

Operator-input block for the FPGA debug top: the input-side counterpart of the 7-segment display path. Three raw active-low pushbuttons are synchronized and debounced, then used to edit a 24-bit hex word one nibble at a time. The word is shown live on HEX0..HEX5, and committed words are offered downstream (instruction/data loader, register poke) over a valid/ready handshake.

---
 rtl/hex_word_entry_pkg.sv | 19 +
 rtl/key_debouncer.sv | 59 +++++
 rtl/hex_word_entry.sv | 147 ++++++++++++++
 tb/tb_hex_word_entry.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_word_entry_pkg.sv
// Shared types and helpers for the operator hex-word entry path.
// Defines the entry FSM state type and the wrapping cursor decrement.
package debug_io_pkg;

  typedef enum logic {
    EDIT  = 1'b0,
    OFFER = 1'b1
  } entry_state_t;

  localparam int NIBBLE_W    = 4;
  localparam int SYNC_STAGES = 2;

  // Cursor moves toward the LSB nibble and wraps from 0 back to the MSB nibble.
  function automatic int unsigned cursor_dec(input int unsigned cursor,
                                             input int unsigned nibbles);
    return (cursor == 0) ? (nibbles - 1) : (cursor - 1);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizer plus counting debouncer for one raw active-low pushbutton.
// level is the debounced pressed state; press_pulse fires once per accepted press.
module key_debouncer
  import debug_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;

  // NOTE: every signal gets a default before any branch, so no latch can be inferred.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ~raw_n};
    synced  = sync_q[SYNC_STAGES-1];
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    // Accept the new level only after the count has already reached the limit.
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = synced;
        pulse_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/hex_word_entry.sv
// Pushbutton-driven hex word editor with a valid/ready commit port.
// Optional inc auto-repeat is enabled by defining HEX_ENTRY_AUTOREPEAT_EN.
module hex_word_entry
  import debug_io_pkg::*;
#(
  parameter int NIBBLES         = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          key_inc_n,
  input  logic                          key_next_n,
  input  logic                          key_commit_n,
  output logic [NIBBLE_W*NIBBLES-1:0]   word_o,
  output logic [$clog2(NIBBLES)-1:0]    cursor_o,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   out_data,
  output logic                          busy
);

  localparam int WORD_W = NIBBLE_W * NIBBLES;
  localparam int CUR_W  = $clog2(NIBBLES);

  logic inc_level, next_level, commit_level;
  logic inc_press, next_press, commit_press;
  logic inc_evt;

  entry_state_t      state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CUR_W-1:0]  cursor_q, cursor_d;
  logic              valid_q, valid_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .raw_n       (key_inc_n),
    .level       (inc_level),
    .press_pulse (inc_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .raw_n       (key_next_n),
    .level       (next_level),
    .press_pulse (next_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_commit (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .raw_n       (key_commit_n),
    .level       (commit_level),
    .press_pulse (commit_press)
  );

`ifdef HEX_ENTRY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;
  logic             unused_levels;

  // Counter is 0 in the press-event cycle, so a fire at REPEAT_CYCLES lands one period later.
  always_comb begin
    rep_fire = inc_level && (state_q == EDIT) && (rep_q == REP_W'(REPEAT_CYCLES));
    rep_d    = '0;
    if (inc_level && (state_q == EDIT)) begin
      rep_d = rep_fire ? REP_W'(1) : rep_q + REP_W'(1);
    end
    inc_evt = inc_press | rep_fire;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign unused_levels = next_level ^ commit_level;
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  logic unused_levels;

  assign inc_evt       = inc_press;
  assign unused_levels = inc_level ^ next_level ^ commit_level;
`endif

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    data_d   = data_q;
    cursor_d = cursor_q;
    valid_d  = valid_q;
    unique case (state_q)
      EDIT: begin
        if (commit_press) begin
          data_d  = word_q;
          valid_d = 1'b1;
          state_d = OFFER;
        end else if (next_press) begin
          cursor_d = CUR_W'(cursor_dec(32'(cursor_q), NIBBLES));
        end else if (inc_evt) begin
          // Nibble wraps on its own; no carry into the neighbour.
          word_d[int'(cursor_q)*NIBBLE_W +: NIBBLE_W] =
            word_q[int'(cursor_q)*NIBBLE_W +: NIBBLE_W] + NIBBLE_W'(1);
        end
      end
      OFFER: begin
        if (valid_q && out_ready) begin
          valid_d  = 1'b0;
          cursor_d = CUR_W'(NIBBLES - 1);
          state_d  = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= EDIT;
      word_q   <= '0;
      data_q   <= '0;
      cursor_q <= CUR_W'(NIBBLES - 1);
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      data_q   <= data_d;
      cursor_q <= cursor_d;
      valid_q  <= valid_d;
    end
  end

  assign word_o    = word_q;
  assign cursor_o  = cursor_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = (state_q == OFFER);

endmodule

// File: tb/tb_hex_word_entry.sv
// Self-checking bench for hex_word_entry: directed cases plus random key sequences
// compared against a transaction-level model of the editor.
module tb_hex_word_entry;

  localparam int NIB  = 6;
  localparam int DB   = 4;
  localparam int REP  = 20;
  localparam int HOLD = 10;
  localparam int GAP  = 12;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        key_inc_n = 1'b1, key_next_n = 1'b1, key_commit_n = 1'b1;
  logic        out_ready = 1'b0;
  logic [23:0] word_o, out_data;
  logic [2:0]  cursor_o;
  logic        out_valid, busy;

  hex_word_entry #(
    .NIBBLES(NIB), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(REP)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .key_inc_n    (key_inc_n),
    .key_next_n   (key_next_n),
    .key_commit_n (key_commit_n),
    .word_o       (word_o),
    .cursor_o     (cursor_o),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one entry per accepted key event.
  logic [23:0] m_word, m_data;
  int          m_cur;
  bit          m_offer;

  function automatic void m_reset();
    m_word = '0; m_data = '0; m_cur = NIB - 1; m_offer = 0;
  endfunction

  function automatic void m_event(input bit inc, input bit nxt, input bit cmt);
    int nib;
    if (m_offer) return;
    if (cmt) begin
      m_data  = m_word;
      m_offer = 1;
    end else if (nxt) begin
      m_cur = (m_cur + NIB - 1) % NIB;
    end else if (inc) begin
      nib    = (int'(m_word) >> (4 * m_cur)) & 15;
      nib    = (nib + 1) % 16;
      m_word = (m_word & ~(24'hF << (4 * m_cur))) | (24'(nib) << (4 * m_cur));
    end
  endfunction

  function automatic void m_handshake();
    m_offer = 0;
    m_cur   = NIB - 1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".word"},   32'(word_o),    32'(m_word));
    check({tag, ".cursor"}, 32'(cursor_o),  32'(m_cur));
    check({tag, ".valid"},  32'(out_valid), 32'(m_offer));
    check({tag, ".busy"},   32'(busy),      32'(m_offer));
    check({tag, ".data"},   32'(out_data),  32'(m_data));
  endtask

  task automatic press(input bit inc, input bit nxt, input bit cmt);
    @(negedge CLOCK_50);
    key_inc_n = ~inc; key_next_n = ~nxt; key_commit_n = ~cmt;
    repeat (HOLD) @(negedge CLOCK_50);
    key_inc_n = 1'b1; key_next_n = 1'b1; key_commit_n = 1'b1;
    repeat (GAP) @(negedge CLOCK_50);
    m_event(inc, nxt, cmt);
  endtask

  task automatic handshake(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge CLOCK_50);
      check("offer_hold.valid", 32'(out_valid), 32'(1));
      check("offer_hold.data",  32'(out_data),  32'(m_data));
    end
    @(negedge CLOCK_50);
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
    m_handshake();
    check_all("handshake");
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    m_reset();
    check_all("reset");
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic enter_word(input logic [23:0] target);
    for (int i = NIB - 1; i >= 0; i--) begin
      int n;
      n = ((int'(target >> (4 * i)) & 15) - (int'(m_word >> (4 * i)) & 15) + 16) % 16;
      repeat (n) press(1, 0, 0);
      press(0, 1, 0);
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check_all("post_reset");

    // Exact latency of the first inc press.
    @(negedge CLOCK_50);
    key_inc_n = 1'b0;
    @(posedge CLOCK_50);
    repeat (DB + 2) @(posedge CLOCK_50);
    #1 check("latency.before", 32'(word_o), 32'h000000);
    @(posedge CLOCK_50);
    #1 check("latency.edge", 32'(word_o), 32'h100000);
    @(negedge CLOCK_50);
    key_inc_n = 1'b1;
    repeat (GAP + 2) @(negedge CLOCK_50);
    m_event(1, 0, 0);
    check_all("first_inc");

    // Short glitch is filtered, a proper press is accepted once.
    @(negedge CLOCK_50);
    key_inc_n = 1'b0;
    repeat (DB - 1) @(negedge CLOCK_50);
    key_inc_n = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    check_all("glitch");
    press(1, 0, 0);
    check_all("after_glitch");

    // Word entry, cursor wrap and nibble wrap.
    do_reset();
    enter_word(24'hA5F00C);
    check("enter.word", 32'(word_o), 32'hA5F00C);
    check("enter.cursor_wrap", 32'(cursor_o), 32'd5);
    repeat (16) press(1, 0, 0);
    check_all("nibble_wrap");
    check("nibble_wrap.word", 32'(word_o), 32'hA5F00C);

    // Commit with a stalled consumer; inc presses in OFFER are ignored.
    do_reset();
    enter_word(24'h123456);
    press(0, 0, 1);
    check_all("commit");
    check("commit.data", 32'(out_data), 32'h123456);
    press(1, 0, 0);
    press(1, 1, 0);
    check_all("offer_keys");
    handshake(10);
    check("release.word", 32'(word_o), 32'h123456);

    // All three keys at once: commit wins.
    press(1, 1, 1);
    check_all("simul");
    handshake(2);

    // Random key traffic.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)       press(1, 0, 0);
      else if (r < 8)  press(0, 1, 0);
      else if (r == 8) press(0, 0, 1);
      else begin
        logic [2:0] m;
        m = 3'($urandom_range(1, 7));
        press(m[0], m[1], m[2]);
      end
      check_all("rand");
      if (m_offer) begin
        if ($urandom_range(0, 1) == 1) begin
          press(1, 0, 0);
          check_all("rand_offer");
        end
        handshake($urandom_range(0, 5));
      end
    end

    // Reset in the middle of an offer.
    press(0, 0, 1);
    check_all("pre_abort");
    do_reset();

    // Long inc hold: debounced level stays up about HOLD_LONG cycles, repeats every REP.
    begin
      int hold_long, n_evt;
      hold_long = 70;
`ifdef HEX_ENTRY_AUTOREPEAT_EN
      n_evt = 1 + (hold_long - 1) / REP;
`else
      n_evt = 1;
`endif
      @(negedge CLOCK_50);
      key_inc_n = 1'b0;
      repeat (hold_long) @(negedge CLOCK_50);
      key_inc_n = 1'b1;
      repeat (15) @(negedge CLOCK_50);
      repeat (n_evt) m_event(1, 0, 0);
      check_all("long_hold");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
